bus_dev_port: RTL and testbench
===============================

Name: bus_dev_port

Overview:
- Device-side endpoint of the bus generator/arbiter (bs_gnrtr_n_rbtr) handshake. The arbiter pulls packets and pushes packets; this block is the FIFO pair it talks to for one device slot.
- Transmit FIFO: the local host writes packets, the arbiter pulls them via pndng/pop/D_pop.
- Receive FIFO: the arbiter delivers packets via push/D_push. Packets are filtered by destination ID (or broadcast) and read by the local host.
- One instance per device; the bench replaces its behavioural FIFO model with this RTL.

Parameters:
- pckg_sz, 16, packet width in bits; destination ID is bits [pckg_sz-1 -: 8].
- depth, 8, entries per FIFO (power of two, >=2).
- id, 0, this device's 8-bit address.
- broadcast, 8'hFF, destination value accepted by all devices.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- tx_wr  in  1  host write strobe into TX FIFO.
- tx_data  in  pckg_sz  host packet to transmit.
- tx_full  out  1  TX FIFO full.
- pndng  out  1  TX FIFO non-empty (to arbiter).
- D_pop  out  pckg_sz  TX FIFO head, show-ahead (to arbiter).
- pop  in  1  arbiter consumes TX head this cycle.
- push  in  1  arbiter delivers D_push this cycle.
- D_push  in  pckg_sz  packet from arbiter.
- rx_rd  in  1  host consumes RX head.
- rx_data  out  pckg_sz  RX FIFO head, show-ahead.
- rx_empty  out  1  RX FIFO empty.
- tx_ovf  out  1  sticky: tx_wr dropped while full.
- rx_ovf  out  1  sticky: accepted push dropped while RX full.
- pop_err  out  1  sticky: pop while TX empty.
- mis_cnt  out  8  saturating count of pushes rejected by the address filter.

Behaviour:
- Reset (reset=0, async): pointers and counts cleared; pndng=0, tx_full=0, rx_empty=1, all sticky flags=0, mis_cnt=0. D_pop and rx_data=0 while empty. Packet storage contents are not reset.
- TX FIFO, circular with occupancy counter of width clog2(depth)+1; pointers wrap modulo depth.
  - pndng = (count!=0). tx_full = (count==depth). Both registered-state derived, no combinational path from inputs.
  - D_pop = mem[rd_ptr] whenever pndng=1. Zero-latency show-ahead: the arbiter samples D_pop in the same cycle it asserts pop.
  - pop with pndng=1: rd_ptr++ at the edge; the next entry appears on D_pop the following cycle.
  - pop with pndng=0: ignored, pop_err<=1.
  - tx_wr with count<depth: write at wr_ptr.
  - tx_wr while full with simultaneous valid pop: write accepted, count unchanged.
  - tx_wr while full without pop: dropped, tx_ovf<=1.
  - Write to an empty FIFO: visible on D_pop/pndng the next cycle. No same-cycle bypass.
- RX FIFO:
  - On push, dst = D_push[pckg_sz-1 -: 8]. Accept if dst==id or dst==broadcast.
  - Rejected: not stored; mis_cnt++ saturating at 255.
  - Accepted and not full (or full with simultaneous valid rx_rd): stored.
  - Accepted while full without rx_rd: dropped, rx_ovf<=1.
  - rx_empty = (count==0). rx_data = head, show-ahead.
  - rx_rd while empty: ignored, no flag.
  - Push into an empty FIFO: visible on rx_data the cycle after.
- TX and RX paths are fully independent; push and pop may occur in the same cycle.
- Sticky flags clear only on reset.
- Reset asserted mid-transfer discards all queued packets immediately. After reset is released, the first edge processes inputs normally.

Test Plan:
- Reset, then tx_wr 16'h0312, 16'h0545 on consecutive cycles -> pndng=1 one cycle after the first write, D_pop=16'h0312. pop -> next cycle D_pop=16'h0545. Second pop -> pndng=0.
- id=3: push 16'h0377, 16'hFF01, 16'h0599 -> rx_data sequence 16'h0377, 16'hFF01. mis_cnt=1. rx_empty=1 after two rx_rd.
- Fill TX with 8 writes -> tx_full=1. 9th tx_wr without pop -> dropped, tx_ovf=1. 9th tx_wr with simultaneous pop -> accepted, tx_full stays 1, FIFO order intact.
- pop with TX empty -> pop_err=1, pointers unchanged; a subsequent write/pop pair returns the correct data.
- Fill RX with 8 accepted pushes, then a 9th -> rx_ovf=1; reading 8 entries returns the first 8 in order.
- Drive reset=0 asynchronously mid-clock with 3 TX and 2 RX entries -> pndng=0, rx_empty=1, flags=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/bus_dev_port.sv
// Device-side FIFO pair for one slot on the bus generator/arbiter.
// TX: the host writes packets and the arbiter pulls them through pndng/pop/D_pop.
// RX: the arbiter pushes packets, which are filtered by destination ID and read by the host.
module bus_dev_port #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  // Host side of the TX FIFO
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  // Arbiter side of the TX FIFO
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  // Arbiter side of the RX FIFO
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  // Host side of the RX FIFO
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  // Status
  output logic               tx_ovf,
  output logic               rx_ovf,
  output logic               pop_err,
  output logic [7:0]         mis_cnt
);

  localparam int unsigned     PtrW    = $clog2(depth);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(depth);

  // ---------------------------------------------------------------------------
  // TX FIFO state
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [PtrW-1:0]    tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PtrW-1:0]    tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CntW-1:0]    tx_cnt_q, tx_cnt_d;
  logic               tx_ovf_q, tx_ovf_d;
  logic               pop_err_q, pop_err_d;
  logic               tx_pop_ok, tx_wr_ok;

  // ---------------------------------------------------------------------------
  // RX FIFO state
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [PtrW-1:0]    rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PtrW-1:0]    rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CntW-1:0]    rx_cnt_q, rx_cnt_d;
  logic               rx_ovf_q, rx_ovf_d;
  logic [7:0]         mis_cnt_q, mis_cnt_d;
  logic [7:0]         rx_dst;
  logic               rx_accept, rx_rd_ok, rx_wr_ok;

  // TX next-state: a pop frees the head slot in the same edge, so a full FIFO
  // can still take a write when the arbiter pops simultaneously.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    tx_ovf_d    = tx_ovf_q;
    pop_err_d   = pop_err_q;

    tx_pop_ok = pop && (tx_cnt_q != '0);
    tx_wr_ok  = tx_wr && ((tx_cnt_q != CntFull) || tx_pop_ok);

    if (pop && !tx_pop_ok) begin
      pop_err_d = 1'b1;
    end
    if (tx_wr && !tx_wr_ok) begin
      tx_ovf_d = 1'b1;
    end
    if (tx_pop_ok) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PtrW'(1);
    end
    if (tx_wr_ok) begin
      tx_wr_ptr_d = tx_wr_ptr_q + PtrW'(1);
    end

    unique case ({tx_wr_ok, tx_pop_ok})
      2'b10:   tx_cnt_d = tx_cnt_q + CntW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CntW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // RX next-state: address filter first, then the same full/read interplay as TX.
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    rx_ovf_d    = rx_ovf_q;
    mis_cnt_d   = mis_cnt_q;

    rx_dst    = D_push[pckg_sz-1 -: 8];
    rx_accept = push && ((rx_dst == id) || (rx_dst == broadcast));
    rx_rd_ok  = rx_rd && (rx_cnt_q != '0);
    rx_wr_ok  = rx_accept && ((rx_cnt_q != CntFull) || rx_rd_ok);

    if (push && !rx_accept && (mis_cnt_q != 8'hFF)) begin
      mis_cnt_d = mis_cnt_q + 8'd1;
    end
    if (rx_accept && !rx_wr_ok) begin
      rx_ovf_d = 1'b1;
    end
    if (rx_rd_ok) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PtrW'(1);
    end
    if (rx_wr_ok) begin
      rx_wr_ptr_d = rx_wr_ptr_q + PtrW'(1);
    end

    unique case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_cnt_d = rx_cnt_q + CntW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CntW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Control state: pointers, counts and sticky flags, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
      pop_err_q   <= 1'b0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      mis_cnt_q   <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
      pop_err_q   <= pop_err_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  // Packet storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (tx_wr_ok) begin
      tx_mem_q[tx_wr_ptr_q] <= tx_data;
    end
    if (rx_wr_ok) begin
      rx_mem_q[rx_wr_ptr_q] <= D_push;
    end
  end

  // Outputs derive from registered state only; heads are forced to zero when empty.
  always_comb begin
    pndng    = (tx_cnt_q != '0);
    tx_full  = (tx_cnt_q == CntFull);
    D_pop    = pndng ? tx_mem_q[tx_rd_ptr_q] : '0;
    rx_empty = (rx_cnt_q == '0);
    rx_data  = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
    tx_ovf   = tx_ovf_q;
    rx_ovf   = rx_ovf_q;
    pop_err  = pop_err_q;
    mis_cnt  = mis_cnt_q;
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Self-checking bench for bus_dev_port: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_bus_dev_port;

  localparam int unsigned Depth = 8;
  localparam logic [7:0]  DevId = 8'h03;

  logic        clk;
  logic        reset;
  logic        tx_wr;
  logic [15:0] tx_data;
  logic        tx_full;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_rd;
  logic [15:0] rx_data;
  logic        rx_empty;
  logic        tx_ovf;
  logic        rx_ovf;
  logic        pop_err;
  logic [7:0]  mis_cnt;

  bus_dev_port #(
    .pckg_sz  (16),
    .depth    (Depth),
    .id       (DevId),
    .broadcast(8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_wr   (tx_wr),
    .tx_data (tx_data),
    .tx_full (tx_full),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .push    (push),
    .D_push  (D_push),
    .rx_rd   (rx_rd),
    .rx_data (rx_data),
    .rx_empty(rx_empty),
    .tx_ovf  (tx_ovf),
    .rx_ovf  (rx_ovf),
    .pop_err (pop_err),
    .mis_cnt (mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  bit          m_tx_ovf, m_rx_ovf, m_pop_err;
  int unsigned m_mis;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_tx_ovf  = 0;
    m_rx_ovf  = 0;
    m_pop_err = 0;
    m_mis     = 0;
  endtask

  task automatic model_edge(input bit w, input logic [15:0] wd, input bit p,
                            input bit ps, input logic [15:0] pd, input bit r);
    bit popped, rd_ok, acc;
    popped = p && (m_tx.size() > 0);
    if (p && !popped) m_pop_err = 1;
    if (popped) void'(m_tx.pop_front());
    if (w) begin
      if (m_tx.size() < Depth) m_tx.push_back(wd);
      else m_tx_ovf = 1;
    end
    rd_ok = r && (m_rx.size() > 0);
    if (rd_ok) void'(m_rx.pop_front());
    acc = ps && (pd[15:8] == DevId || pd[15:8] == 8'hFF);
    if (ps && !acc && m_mis < 255) m_mis++;
    if (acc) begin
      if (m_rx.size() < Depth) m_rx.push_back(pd);
      else m_rx_ovf = 1;
    end
  endtask

  task automatic compare_all(input string ph);
    check_eq({ph, ".pndng"},    pndng,    m_tx.size() != 0);
    check_eq({ph, ".tx_full"},  tx_full,  m_tx.size() == Depth);
    check_eq({ph, ".d_pop"},    D_pop,    (m_tx.size() != 0) ? m_tx[0] : 16'h0);
    check_eq({ph, ".rx_empty"}, rx_empty, m_rx.size() == 0);
    check_eq({ph, ".rx_data"},  rx_data,  (m_rx.size() != 0) ? m_rx[0] : 16'h0);
    check_eq({ph, ".tx_ovf"},   tx_ovf,   m_tx_ovf);
    check_eq({ph, ".rx_ovf"},   rx_ovf,   m_rx_ovf);
    check_eq({ph, ".pop_err"},  pop_err,  m_pop_err);
    check_eq({ph, ".mis_cnt"},  mis_cnt,  m_mis);
  endtask

  task automatic idle();
    tx_wr = 0; tx_data = '0; pop = 0; push = 0; D_push = '0; rx_rd = 0;
  endtask

  // One clock: drive at the negedge, apply the model at the posedge, check at the next negedge.
  task automatic cycle(input string ph, input bit w, input logic [15:0] wd, input bit p,
                       input bit ps, input logic [15:0] pd, input bit r);
    tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r;
    @(posedge clk);
    model_edge(w, wd, p, ps, pd, r);
    @(negedge clk);
    idle();
    compare_all(ph);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    compare_all("reset");
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    do_reset();

    // Basic TX ordering and show-ahead timing
    cycle("tx1", 1, 16'h0312, 0, 0, 0, 0);
    check_eq("tx1.pndng_const", pndng, 1);
    check_eq("tx1.d_pop_const", D_pop, 16'h0312);
    cycle("tx2", 1, 16'h0545, 0, 0, 0, 0);
    cycle("tx3", 0, 0, 1, 0, 0, 0);
    check_eq("tx3.d_pop_const", D_pop, 16'h0545);
    cycle("tx4", 0, 0, 1, 0, 0, 0);
    check_eq("tx4.pndng_const", pndng, 0);

    // Address filter
    cycle("rx1", 0, 0, 0, 1, 16'h0377, 0);
    cycle("rx2", 0, 0, 0, 1, 16'hFF01, 0);
    cycle("rx3", 0, 0, 0, 1, 16'h0599, 0);
    check_eq("rx3.rx_data_const", rx_data, 16'h0377);
    check_eq("rx3.mis_const", mis_cnt, 8'd1);
    cycle("rx4", 0, 0, 0, 0, 0, 1);
    check_eq("rx4.rx_data_const", rx_data, 16'hFF01);
    cycle("rx5", 0, 0, 0, 0, 0, 1);
    check_eq("rx5.rx_empty_const", rx_empty, 1);
    cycle("rx6", 0, 0, 0, 0, 0, 1);  // read while empty: no flag

    // TX full, drop, and write-with-pop while full
    for (int i = 0; i < 8; i++) cycle("txfill", 1, 16'hA000 + 16'(i), 0, 0, 0, 0);
    check_eq("txfill.full_const", tx_full, 1);
    cycle("txwp", 1, 16'hA0F0, 1, 0, 0, 0);
    check_eq("txwp.full_const", tx_full, 1);
    check_eq("txwp.ovf_const", tx_ovf, 0);
    cycle("txdrop", 1, 16'hBEEF, 0, 0, 0, 0);
    check_eq("txdrop.ovf_const", tx_ovf, 1);
    for (int i = 0; i < 8; i++) cycle("txdrain", 0, 0, 1, 0, 0, 0);

    // Pop while empty, then a write/pop pair
    cycle("poperr", 0, 0, 1, 0, 0, 0);
    check_eq("poperr.const", pop_err, 1);
    cycle("pe_wr", 1, 16'h1234, 0, 0, 0, 0);
    check_eq("pe_wr.d_pop_const", D_pop, 16'h1234);
    cycle("pe_pop", 0, 0, 1, 0, 0, 0);

    // RX full and overflow
    for (int i = 0; i < 8; i++) cycle("rxfill", 0, 0, 0, 1, 16'h0340 + 16'(i), 0);
    cycle("rxovf", 0, 0, 0, 1, 16'hFF99, 0);
    check_eq("rxovf.const", rx_ovf, 1);
    cycle("rxrw", 0, 0, 0, 1, 16'h03AA, 1);  // full with simultaneous read: accepted
    for (int i = 0; i < 8; i++) cycle("rxdrain", 0, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-cycle with traffic queued
    for (int i = 0; i < 3; i++) cycle("prerst_tx", 1, 16'h7700 + 16'(i), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle("prerst_rx", 0, 0, 0, 1, 16'h0360 + 16'(i), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check_eq("async_rst.pndng_const", pndng, 0);
    check_eq("async_rst.rx_empty_const", rx_empty, 1);
    @(negedge clk);
    reset = 1'b1;
    cycle("postrst", 1, 16'h4242, 0, 1, 16'hFF42, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] pd;
      int sel;
      sel = $urandom_range(0, 3);
      pd  = 16'($urandom);
      if (sel == 0) pd[15:8] = DevId;
      else if (sel == 1) pd[15:8] = 8'hFF;
      else if (sel == 2) pd[15:8] = (pd[15:8] == DevId) ? 8'h04 : pd[15:8];
      cycle("rand", ($urandom_range(0, 99) < 55), 16'($urandom), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 55), pd, ($urandom_range(0, 99) < 45));
    end

    // mis_cnt saturation
    do_reset();
    for (int i = 0; i < 260; i++) cycle("missat", 0, 0, 0, 1, 16'h0501, 0);
    check_eq("missat.const", mis_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
